// File: rtl/tdm_demux8_if.sv
// Bundle for the tdm_demux8 receive path: serial slot inputs and the parallel frame outputs.
// The master modport is the side that drives the serial stream.
interface tdm_demux8_if;
  logic       en;
  logic       sync;
  logic       din;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;
  logic [7:0] frame_cnt;

  modport master (
    output en, sync, din,
    input  dout, dout_valid, slot, locked, sync_err, frame_cnt
  );

  modport slave (
    input  en, sync, din,
    output dout, dout_valid, slot, locked, sync_err, frame_cnt
  );
endinterface

// File: rtl/tdm_demux8.sv
// 1-to-8 TDM demultiplexer: aligns on the slot-0 sync marker and emits one 8-bit word per frame.
// A flywheel tolerates up to MISS_LIMIT-1 consecutive missing markers before dropping lock.
module tdm_demux8 #(
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux8_if.slave  bus
);

  typedef enum logic [0:0] {StHunt, StLock} state_e;

  state_e     state_q, state_d;
  logic [6:0] sh_q, sh_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic [2:0] slot_q, slot_d;
  logic       sync_err_q, sync_err_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [2:0] miss_q, miss_d;
  logic [3:0] miss_inc;

  assign miss_inc = {1'b0, miss_q} + 4'd1;

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    slot_d       = slot_q;
    sync_err_d   = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    miss_d       = miss_q;

    if (bus.en) begin
      unique case (state_q)
        StHunt: begin
          if (bus.sync) begin
            sh_d    = {6'd0, bus.din};
            slot_d  = 3'd1;
            miss_d  = 3'd0;
            state_d = StLock;
          end
        end
        StLock: begin
          if (bus.sync && slot_q != 3'd0) begin
            // Early marker: abandon the partial frame and restart alignment here.
            sync_err_d = 1'b1;
            sh_d       = {6'd0, bus.din};
            slot_d     = 3'd1;
          end else if (slot_q == 3'd0) begin
            if (bus.sync) begin
              miss_d    = 3'd0;
              sh_d[0]   = bus.din;
              slot_d    = 3'd1;
            end else begin
              sync_err_d = 1'b1;
              miss_d     = miss_inc[2:0];
              if (miss_inc < 4'(MISS_LIMIT)) begin
                sh_d[0] = bus.din;
                slot_d  = 3'd1;
              end else begin
                state_d = StHunt;
                slot_d  = 3'd0;
                sh_d    = '0;
              end
            end
          end else if (slot_q == 3'd7) begin
            dout_d       = {bus.din, sh_q};
            dout_valid_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            slot_d       = 3'd0;
          end else begin
            sh_d[slot_q] = bus.din;
            slot_d       = slot_q + 3'd1;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHunt;
      sh_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      slot_q       <= '0;
      sync_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      slot_q       <= slot_d;
      sync_err_q   <= sync_err_d;
      frame_cnt_q  <= frame_cnt_d;
      miss_q       <= miss_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slot       = slot_q;
  assign bus.locked     = (state_q == StLock);
  assign bus.sync_err   = sync_err_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: lock, en gaps, early sync, flywheel loss, async reset, wrap.
module tb_tdm_demux8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  tdm_demux8_if bus ();

  tdm_demux8 #(.MISS_LIMIT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, leave sampling point 1ns after the rising edge.
  task automatic cyc(input logic e, input logic s, input logic d);
    @(negedge clk);
    bus.en   = e;
    bus.sync = s;
    bus.din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] d, input logic s0, input logic [7:0] cnt,
                       input string tag);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, (k == 0) ? s0 : 1'b0, d[k]);
      if (k < 7) chk({tag, "_novalid"}, {31'd0, bus.dout_valid}, 32'd0);
    end
    chk({tag, "_dout"},  {24'd0, bus.dout}, {24'd0, d});
    chk({tag, "_valid"}, {31'd0, bus.dout_valid}, 32'd1);
    chk({tag, "_cnt"},   {24'd0, bus.frame_cnt}, {24'd0, cnt});
    chk({tag, "_slot"},  {29'd0, bus.slot}, 32'd0);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] cnt;
    n_chk    = 0;
    n_err    = 0;
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    bus.din  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout",   {24'd0, bus.dout}, 32'd0);
    chk("rst_valid",  {31'd0, bus.dout_valid}, 32'd0);
    chk("rst_slot",   {29'd0, bus.slot}, 32'd0);
    chk("rst_locked", {31'd0, bus.locked}, 32'd0);
    chk("rst_err",    {31'd0, bus.sync_err}, 32'd0);
    chk("rst_cnt",    {24'd0, bus.frame_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // HUNT ignores data without sync.
    cyc(1'b1, 1'b0, 1'b1);
    chk("hunt_ign_locked", {31'd0, bus.locked}, 32'd0);
    chk("hunt_ign_slot",   {29'd0, bus.slot}, 32'd0);

    // Basic frame: slots 1,0,1,1,0,0,1,0 -> 8'h4D.
    pat = 8'h4D;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, k == 0, pat[k]);
      chk("f1_locked", {31'd0, bus.locked}, 32'd1);
      if (k < 7) chk("f1_slot", {29'd0, bus.slot}, k + 1);
    end
    chk("f1_dout",  {24'd0, bus.dout}, 32'h4D);
    chk("f1_valid", {31'd0, bus.dout_valid}, 32'd1);
    chk("f1_cnt",   {24'd0, bus.frame_cnt}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("f1_pulse_w", {31'd0, bus.dout_valid}, 32'd0);

    // en gaps: idle cycles carry inverted data and stray sync that must be ignored.
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, k == 0, pat[k]);
      cyc(1'b0, 1'b1, ~pat[k]);
      chk("gap_slot", {29'd0, bus.slot}, (k + 1) % 8);
      if (k == 7) chk("gap_valid_clr", {31'd0, bus.dout_valid}, 32'd0);
    end
    chk("gap_dout", {24'd0, bus.dout}, 32'h4D);
    chk("gap_cnt",  {24'd0, bus.frame_cnt}, 32'd2);

    // Early sync at slot 4 restarts the frame; new frame carries 8'hA5 (bit0 on the sync cycle).
    pat = 8'h3C;
    for (int k = 0; k < 4; k++) cyc(1'b1, k == 0, pat[k]);
    cyc(1'b1, 1'b1, 1'b1);
    chk("early_err",    {31'd0, bus.sync_err}, 32'd1);
    chk("early_valid",  {31'd0, bus.dout_valid}, 32'd0);
    chk("early_slot",   {29'd0, bus.slot}, 32'd1);
    chk("early_locked", {31'd0, bus.locked}, 32'd1);
    pat = 8'hA5;
    for (int k = 1; k < 8; k++) begin
      cyc(1'b1, 1'b0, pat[k]);
      if (k == 1) chk("early_err_clr", {31'd0, bus.sync_err}, 32'd0);
    end
    chk("early_dout", {24'd0, bus.dout}, 32'hA5);
    chk("early_cnt",  {24'd0, bus.frame_cnt}, 32'd3);
    frame(8'h3C, 1'b1, 8'd4, "clean");

    // Flywheel: first missing marker tolerated, second drops lock.
    pat = 8'h96;
    cyc(1'b1, 1'b0, pat[0]);
    chk("miss1_err",    {31'd0, bus.sync_err}, 32'd1);
    chk("miss1_locked", {31'd0, bus.locked}, 32'd1);
    chk("miss1_slot",   {29'd0, bus.slot}, 32'd1);
    for (int k = 1; k < 8; k++) cyc(1'b1, 1'b0, pat[k]);
    chk("miss1_dout",  {24'd0, bus.dout}, 32'h96);
    chk("miss1_valid", {31'd0, bus.dout_valid}, 32'd1);
    chk("miss1_cnt",   {24'd0, bus.frame_cnt}, 32'd5);
    cyc(1'b1, 1'b0, 1'b1);
    chk("miss2_err",    {31'd0, bus.sync_err}, 32'd1);
    chk("miss2_locked", {31'd0, bus.locked}, 32'd0);
    chk("miss2_slot",   {29'd0, bus.slot}, 32'd0);
    chk("miss2_dout",   {24'd0, bus.dout}, 32'h96);
    cyc(1'b1, 1'b0, 1'b0);
    chk("hunt_locked", {31'd0, bus.locked}, 32'd0);
    chk("hunt_err",    {31'd0, bus.sync_err}, 32'd0);
    chk("hunt_dout",   {24'd0, bus.dout}, 32'h96);

    // Relock, then async reset in the middle of a frame.
    frame(8'h4D, 1'b1, 8'd6, "relock");
    pat = 8'hFF;
    for (int k = 0; k < 5; k++) cyc(1'b1, k == 0, pat[k]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dout",   {24'd0, bus.dout}, 32'd0);
    chk("arst_slot",   {29'd0, bus.slot}, 32'd0);
    chk("arst_locked", {31'd0, bus.locked}, 32'd0);
    chk("arst_cnt",    {24'd0, bus.frame_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 5; k < 8; k++) begin
      cyc(1'b1, 1'b0, pat[k]);
      chk("arst_novalid", {31'd0, bus.dout_valid}, 32'd0);
    end
    chk("arst_hunt", {31'd0, bus.locked}, 32'd0);

    // 256 clean frames: counter wraps to 0.
    cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      pat = 8'(i) ^ 8'h5A;
      cnt = cnt + 8'd1;
      frame(pat, 1'b1, cnt, "wrap");
    end
    chk("wrap_zero", {24'd0, bus.frame_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
